// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-buffer entry type used by fetch and decode.
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: imem request/response channels, instruction output and redirect.
// master = fetch unit side, slave = memory/decoder/branch side.
interface instr_fetch_unit_if;
  import rv32i_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; data visible the cycle after push.
// Push while full is accepted only alongside a pop; flush has priority over push/pop.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_dat,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner: issues word fetches under a FIFO_DEPTH credit limit, buffers {instr, pc}, flushes on redirect.
// Request one cycle after reset/redirect; instr_valid one cycle after a response; stalls fetch when buffer+in-flight is full.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int DROP_MAX = (2 ** CW) - 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [CW-1:0]   live_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   live_nxt;
  logic [CW-1:0]   drop_nxt;
  logic [CW:0]     drop_sum;
  logic [CW:0]     credit_sum;
  logic            drop_sat;
  logic            req_fire;
  logic            rsp_owed;
  logic            push;
  logic            pop;

  fetch_entry_t    push_dat;
  fetch_entry_t    head_dat;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  assign redirect_tgt = bus.redirect_pc & ~XLEN'(INSTR_BYTES - 1);
  assign credit_sum   = {1'b0, fifo_count} + {1'b0, live_cnt};

  // Gated by rst_n so the request channel is quiet while reset is held.
  assign bus.imem_req_valid = rst_n && (drop_cnt == '0) &&
                              (credit_sum < (CW+1)'(FIFO_DEPTH)) && !bus.redirect_valid;
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses with nothing outstanding (e.g. stragglers from before reset) are ignored.
  assign rsp_owed = bus.imem_rsp_valid && ((drop_cnt != '0) || (live_cnt != '0));
  assign push     = rsp_owed && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop      = bus.instr_valid && bus.instr_ready;
  assign push_dat = '{instr: bus.imem_rsp_data, pc: rsp_pc};

  always_comb begin
    live_nxt = live_cnt;
    drop_nxt = drop_cnt;
    drop_sum = {1'b0, drop_cnt} + {1'b0, live_cnt} - (CW+1)'(rsp_owed);
    drop_sat = 1'b0;
    if (bus.redirect_valid) begin
      live_nxt = '0;
      if (drop_sum > (CW+1)'(DROP_MAX)) begin
        drop_nxt = CW'(DROP_MAX);
        drop_sat = 1'b1;
      end else begin
        drop_nxt = drop_sum[CW-1:0];
      end
    end else begin
      if (rsp_owed && (drop_cnt != '0)) drop_nxt = drop_cnt - CW'(1);
      live_nxt = live_cnt + CW'(req_fire) - CW'(push);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      live_cnt <= live_nxt;
      drop_cnt <= drop_nxt;
      if (bus.redirect_valid) begin
        pc     <= redirect_tgt;
        rsp_pc <= redirect_tgt;
      end else begin
        if (req_fire) pc     <= pc + XLEN'(INSTR_BYTES);
        if (push)     rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? '0 : head_dat.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head_dat.pc;

  a_credit_holds: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));
  a_drop_no_sat: assert property (@(posedge clk) disable iff (!rst_n) !drop_sat);

endmodule
